// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-stage bundle: hazard/EX control inputs, imem handshake and IF/ID outputs.
interface fetch_pc_sequencer_if;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        misalign_fault;

  modport master (
    input  stall_fetch, redirect_valid, redirect_target, imem_ready,
    output imem_req, imem_addr, pc_out, instr_valid, misalign_fault
  );

  modport slave (
    output stall_fetch, redirect_valid, redirect_target, imem_ready,
    input  imem_req, imem_addr, pc_out, instr_valid, misalign_fault
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register and imem request sequencer: boot vector, EX redirect or PC+step.
//   state | meaning
//   BOOT  | one bubble after reset, no request
//   FETCH | requesting imem at fetch_pc
//   FAULT | misaligned redirect seen, fetch halted until aligned redirect
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input logic                  clk,
  input logic                  rst,
  fetch_pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] pc_out_q, pc_out_nxt;
  logic        valid_q, valid_nxt;
  logic        fault_q, fault_nxt;
  logic        target_aligned;

  assign target_aligned = (bus.redirect_target[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_VECTOR;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pc_out_q <= pc_out_nxt;
      valid_q  <= valid_nxt;
      fault_q  <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pc_out_nxt   = pc_out_q;
    valid_nxt    = valid_q;
    fault_nxt    = fault_q;
    case (state)
      BOOT: begin
        state_nxt = FETCH;
        valid_nxt = 1'b0;
      end
      FETCH: begin
        // Redirect squashes any same-cycle imem response, even under stall.
        if (bus.redirect_valid) begin
          valid_nxt = 1'b0;
          if (target_aligned) begin
            fetch_pc_nxt = bus.redirect_target;
          end else begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end
        end else if (bus.stall_fetch) begin
          state_nxt = FETCH;
        end else if (bus.imem_ready) begin
          pc_out_nxt   = fetch_pc;
          valid_nxt    = 1'b1;
          fetch_pc_nxt = fetch_pc + PC_STEP;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      FAULT: begin
        valid_nxt = 1'b0;
        fault_nxt = 1'b1;
        if (bus.redirect_valid && target_aligned) begin
          state_nxt    = FETCH;
          fetch_pc_nxt = bus.redirect_target;
          fault_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.imem_req       = (state == FETCH);
  assign bus.imem_addr      = fetch_pc;
  assign bus.pc_out         = pc_out_q;
  assign bus.instr_valid    = valid_q;
  assign bus.misalign_fault = fault_q;

endmodule
